// File: rtl/panel_input_ctrl_if.sv
`timescale 1ns/1ps
// Front-panel input bundle: raw button/encoder inputs towards the controller and
// debounced button / rotary results back from it.
interface panel_input_ctrl_if #(
  parameter int NUM_BTN   = 5,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_BTN-1:0]   iBtn;
  logic                 iRotA;
  logic                 iRotB;
  logic                 iCountClear;
  logic [NUM_BTN-1:0]   oBtnLevel;
  logic [NUM_BTN-1:0]   oBtnPress;
  logic                 oRotStep;
  logic                 oRotDir;
  logic [CNT_WIDTH-1:0] oRotCount;

  modport master (
    output iBtn, iRotA, iRotB, iCountClear,
    input  oBtnLevel, oBtnPress, oRotStep, oRotDir, oRotCount
  );

  modport slave (
    input  iBtn, iRotA, iRotB, iCountClear,
    output oBtnLevel, oBtnPress, oRotStep, oRotDir, oRotCount
  );
endinterface

// File: rtl/panel_input_ctrl.sv
`timescale 1ns/1ps
// Debounced push-buttons with one-cycle press pulses plus a filtered rotary encoder position counter.
// Define BTN_AUTOREPEAT_EN to build per-button auto-repeat of the press pulse.
module panel_input_ctrl #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 8,
  parameter int CNT_MODE        = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic              Clock,
  input  logic              Reset,
  panel_input_ctrl_if.slave bus
);

  localparam int                   DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (NUM_BTN < 1 || NUM_BTN > 16 || DEBOUNCE_CYCLES < 2 || CNT_WIDTH < 2 || CNT_WIDTH > 16 ||
      CNT_MODE < 0 || CNT_MODE > 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("panel_input_ctrl: parameter out of range");
  end

  logic [NUM_BTN-1:0]   btn_s1_q, btn_s2_q;
  logic [1:0]           rot_s1_q, rot_s2_q;
  logic [DB_W-1:0]      db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]      db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0]   level_q, level_d;
  logic [NUM_BTN-1:0]   press_q, press_d;
  logic [NUM_BTN-1:0]   rpt_pulse;
  logic                 q1_q, q1_d, q2_q, q2_d;
  logic                 step_q, step_d, dir_q, dir_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rot_a, rot_b;

  assign rot_a = rot_s2_q[1];
  assign rot_b = rot_s2_q[0];

  // Debounce: a channel flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
          press_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_first_q, rpt_first_d;

  // Timer counts cycles since the last pulse; the first interval uses the longer delay.
  always_comb begin
    rpt_pulse   = '0;
    rpt_first_d = rpt_first_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (press_d[i]) begin
        rpt_cnt_d[i]   = RPT_W'(1);
        rpt_first_d[i] = 1'b1;
      end else if (!level_q[i] || !level_d[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end else if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE))) begin
        rpt_pulse[i]   = 1'b1;
        rpt_cnt_d[i]   = RPT_W'(1);
        rpt_first_d[i] = 1'b0;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rpt_first_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  // Rotary hysteresis filter; a detent is the rising edge of q1.
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    if (rot_a && rot_b)        q1_d = 1'b1;
    else if (!rot_a && !rot_b) q1_d = 1'b0;
    if (rot_a && !rot_b)       q2_d = 1'b1;
    else if (!rot_a && rot_b)  q2_d = 1'b0;
    step_d = q1_d & ~q1_q;
    dir_d  = step_d ? ~q2_q : dir_q;
  end

  // Position follows the registered step one cycle later; clear has priority.
  always_comb begin
    count_d = count_q;
    if (bus.iCountClear) begin
      count_d = '0;
    end else if (step_q) begin
      if (dir_q) begin
        if (!(CNT_MODE == 1 && count_q == CNT_MAX)) count_d = count_q + 1'b1;
      end else begin
        if (!(CNT_MODE == 1 && count_q == '0)) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      rot_s1_q <= '0;
      rot_s2_q <= '0;
      level_q  <= '0;
      press_q  <= '0;
      q1_q     <= 1'b0;
      q2_q     <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_s1_q <= bus.iBtn;
      btn_s2_q <= btn_s1_q;
      rot_s1_q <= {bus.iRotA, bus.iRotB};
      rot_s2_q <= rot_s1_q;
      level_q  <= level_d;
      press_q  <= press_d | rpt_pulse;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign bus.oBtnLevel = level_q;
  assign bus.oBtnPress = press_q;
  assign bus.oRotStep  = step_q;
  assign bus.oRotDir   = dir_q;
  assign bus.oRotCount = count_q;

endmodule

// File: tb/tb_panel_input_ctrl.sv
`timescale 1ns/1ps
// Directed bench for panel_input_ctrl: one wrapping and one saturating instance share stimulus.
module tb_panel_input_ctrl;
  localparam int NB = 3;
  localparam int DB = 4;
  localparam int CW = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic rot_a = 1'b0, rot_b = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  panel_input_ctrl_if #(.NUM_BTN(NB), .CNT_WIDTH(CW)) bw ();
  panel_input_ctrl_if #(.NUM_BTN(NB), .CNT_WIDTH(CW)) bs ();

  assign bw.iBtn = btn;  assign bw.iRotA = rot_a;  assign bw.iRotB = rot_b;  assign bw.iCountClear = clr;
  assign bs.iBtn = btn;  assign bs.iRotA = rot_a;  assign bs.iRotB = rot_b;  assign bs.iCountClear = clr;

  panel_input_ctrl #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW), .CNT_MODE(0),
                     .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_wrap (.Clock(clk), .Reset(rst), .bus(bw));
  panel_input_ctrl #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW), .CNT_MODE(1),
                     .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_sat (.Clock(clk), .Reset(rst), .bus(bs));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int step_w = 0, step_s = 0;
  int press_cnt [NB];
  int last_press [NB];
  int p0_q [$];

  initial for (int i = 0; i < NB; i++) begin press_cnt[i] = 0; last_press[i] = 0; end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bw.oRotStep) step_w++;
    if (bs.oRotStep) step_s++;
    for (int i = 0; i < NB; i++)
      if (bw.oBtnPress[i]) begin press_cnt[i]++; last_press[i] = cyc; end
    if (bw.oBtnPress[0]) p0_q.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Clockwise: B leads A, so q2 is cleared before q1 rises.
  task automatic detent(input bit cw);
    logic [1:0] seq [4];
    if (cw) seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    else    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int k = 0; k < 4; k++) begin
      {rot_a, rot_b} = seq[k];
      tick(3);
    end
  endtask

  typedef struct {
    bit cw;
    int n;
    int exp_w;
    int exp_s;
    int exp_dir;
  } rot_vec_t;

  rot_vec_t tbl [7];

  initial begin
    int lat, sw0, ss0, pc, pc1, pc2, found, t0;
    tbl[0] = '{cw: 1'b1, n: 4,  exp_w: 4,  exp_s: 4,  exp_dir: 1};
    tbl[1] = '{cw: 1'b0, n: 4,  exp_w: 0,  exp_s: 0,  exp_dir: 0};
    tbl[2] = '{cw: 1'b0, n: 1,  exp_w: 15, exp_s: 0,  exp_dir: 0};
    tbl[3] = '{cw: 1'b1, n: 1,  exp_w: 0,  exp_s: 1,  exp_dir: 1};
    tbl[4] = '{cw: 1'b1, n: 14, exp_w: 14, exp_s: 15, exp_dir: 1};
    tbl[5] = '{cw: 1'b1, n: 1,  exp_w: 15, exp_s: 15, exp_dir: 1};
    tbl[6] = '{cw: 1'b1, n: 1,  exp_w: 0,  exp_s: 15, exp_dir: 1};

    // Reset state
    tick(3);
    chk("rst_level", int'(bw.oBtnLevel), 0);
    chk("rst_press", int'(bw.oBtnPress), 0);
    chk("rst_step", int'(bw.oRotStep), 0);
    chk("rst_dir", int'(bw.oRotDir), 0);
    chk("rst_count_w", int'(bw.oRotCount), 0);
    chk("rst_count_s", int'(bs.oRotCount), 0);
    rst = 1'b0;
    tick(2);

    // Bouncing button 0, then a clean press
    for (int k = 0; k < 10; k++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    chk("bounce_press", press_cnt[0], 0);
    chk("bounce_level", int'(bw.oBtnLevel[0]), 0);
    btn[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bw.oBtnLevel[0]) begin lat = k; break; end
    end
    chk("btn0_latency_in_window", int'(lat >= DB && lat <= DB + 3), 1);
    tick(3);
    chk("btn0_single_press", press_cnt[0], 1);
    chk("btn0_level_held", int'(bw.oBtnLevel[0]), 1);
    btn[0] = 1'b0;
    tick(10);
    chk("btn0_release_level", int'(bw.oBtnLevel[0]), 0);
    chk("btn0_release_no_pulse", press_cnt[0], 1);

    // Glitch one cycle shorter than the debounce window
    btn[2] = 1'b1;
    tick(DB - 1);
    btn[2] = 1'b0;
    tick(10);
    chk("glitch_level", int'(bw.oBtnLevel[2]), 0);
    chk("glitch_press", press_cnt[2], 0);

    // Two channels pressed one cycle apart
    pc1 = press_cnt[1];
    pc2 = press_cnt[2];
    btn[1] = 1'b1;
    tick();
    btn[2] = 1'b1;
    tick(10);
    chk("multi_press1", press_cnt[1] - pc1, 1);
    chk("multi_press2", press_cnt[2] - pc2, 1);
    chk("multi_press_spacing", last_press[2] - last_press[1], 1);
    btn[1] = 1'b0;
    btn[2] = 1'b0;
    tick(10);
    chk("multi_release", int'(bw.oBtnLevel), 0);

    // Rotary table
    for (int v = 0; v < 7; v++) begin
      sw0 = step_w;
      ss0 = step_s;
      for (int k = 0; k < tbl[v].n; k++) detent(tbl[v].cw);
      tick(4);
      chk($sformatf("rot%0d_count_wrap", v), int'(bw.oRotCount), tbl[v].exp_w);
      chk($sformatf("rot%0d_count_sat", v), int'(bs.oRotCount), tbl[v].exp_s);
      chk($sformatf("rot%0d_dir", v), int'(bw.oRotDir), tbl[v].exp_dir);
      chk($sformatf("rot%0d_steps_wrap", v), step_w - sw0, tbl[v].n);
      chk($sformatf("rot%0d_steps_sat", v), step_s - ss0, tbl[v].n);
    end

    // Clear on its own, then clear colliding with a detent update at count 7
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_sat", int'(bs.oRotCount), 0);
    chk("clear_wrap", int'(bw.oRotCount), 0);
    for (int k = 0; k < 7; k++) detent(1'b1);
    tick(4);
    chk("pre_collide_count", int'(bw.oRotCount), 7);
    {rot_a, rot_b} = 2'b01;
    tick(3);
    {rot_a, rot_b} = 2'b11;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bw.oRotStep) begin found = 1; break; end
    end
    chk("collide_step_seen", found, 1);
    chk("collide_count_before", int'(bw.oRotCount), 7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("collide_clear_wrap", int'(bw.oRotCount), 0);
    chk("collide_clear_sat", int'(bs.oRotCount), 0);
    {rot_a, rot_b} = 2'b10;
    tick(3);
    {rot_a, rot_b} = 2'b00;
    tick(5);
    chk("collide_no_late_update", int'(bw.oRotCount), 0);

    // Long hold on button 0
    p0_q.delete();
    btn[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (p0_q.size() > 0) begin found = 1; break; end
    end
    chk("hold_first_press", found, 1);
    t0 = (p0_q.size() > 0) ? p0_q[0] : 0;
    tick(50);
    btn[0] = 1'b0;
    tick(12);
`ifdef BTN_AUTOREPEAT_EN
    chk("repeat_count", p0_q.size(), 6);
    for (int k = 1; k < 6; k++)
      if (k < p0_q.size()) chk($sformatf("repeat_offset%0d", k), p0_q[k] - t0, RD + (k - 1) * RR);
`else
    chk("repeat_count", p0_q.size(), 1);
`endif

    // Reset while button 1 is held and the encoder has moved
    detent(1'b1);
    tick(4);
    chk("pre_reset_count", int'(bw.oRotCount), 1);
    btn[1] = 1'b1;
    tick(10);
    chk("pre_reset_level1", int'(bw.oBtnLevel[1]), 1);
    pc = press_cnt[1];
    rst = 1'b1;
    #2;
    chk("in_reset_level", int'(bw.oBtnLevel), 0);
    chk("in_reset_press", int'(bw.oBtnPress), 0);
    chk("in_reset_step", int'(bw.oRotStep), 0);
    chk("in_reset_dir", int'(bw.oRotDir), 0);
    chk("in_reset_count_w", int'(bw.oRotCount), 0);
    chk("in_reset_count_s", int'(bs.oRotCount), 0);
    tick(3);
    chk("held_reset_level", int'(bw.oBtnLevel), 0);
    rst = 1'b0;
    tick(4);
    chk("post_reset_no_early_pulse", press_cnt[1] - pc, 0);
    chk("post_reset_level_low", int'(bw.oBtnLevel[1]), 0);
    tick(6);
    chk("post_reset_requal_pulse", press_cnt[1] - pc, 1);
    chk("post_reset_level_high", int'(bw.oBtnLevel[1]), 1);
    btn[1] = 1'b0;
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
